// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants and types for the UDP transmit path.
package eth_pkg;

  localparam int unsigned eth_ip_udp_header_addr_width = 3;
  localparam int unsigned eth_udp_length_width         = 16;
  localparam int unsigned eth_ipv4_header_length       = 20;
  localparam int unsigned eth_udp_header_length        = 8;
  localparam int unsigned eth_ip_udp_header_words      = 7;
  localparam int unsigned eth_ip_udp_header_bytes      =
    eth_ipv4_header_length + eth_udp_header_length;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEADER,
    TX_PAYLOAD
  } udp_tx_state_e;

  // One byte-wide stream beat.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } eth_axis_byte_t;

endpackage

// File: rtl/udp_tx_if.sv
// Payload-source and MAC-payload stream bundle around the UDP transmit framer.
interface udp_tx_if;
  import eth_pkg::*;

  logic [eth_udp_length_width-1:0] udp_length;
  logic [7:0]                      udp_data;
  logic                            udp_valid;
  logic                            udp_last;
  logic                            udp_ready;

  logic [7:0]                      mac_payload_data;
  logic                            mac_payload_valid;
  logic                            mac_payload_last;
  logic                            mac_payload_ready;

  // Framer side: consumes the UDP payload stream, produces the MAC stream.
  modport slave (
    input  udp_length, udp_data, udp_valid, udp_last,
    output udp_ready,
    output mac_payload_data, mac_payload_valid, mac_payload_last,
    input  mac_payload_ready
  );

  // Environment side: payload source and MAC sink.
  modport master (
    output udp_length, udp_data, udp_valid, udp_last,
    input  udp_ready,
    input  mac_payload_data, mac_payload_valid, mac_payload_last,
    output mac_payload_ready
  );

endinterface

// File: rtl/udp_tx.sv
// IPv4/UDP transmit framer: emits a 28-byte header template with lengths and IP
// checksum patched in, followed by the payload, as one byte-wide stream frame.
module udp_tx
  import eth_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    header_wr_en_i,
  input  logic [eth_ip_udp_header_addr_width-1:0] header_wr_addr_i,
  input  logic [31:0]                             header_wr_data_i,
  udp_tx_if.slave                                 tx_if
);

  localparam int unsigned idx_w = 5;
  localparam int unsigned len_w = eth_udp_length_width;
  localparam int unsigned aw    = eth_ip_udp_header_addr_width;

  localparam logic [idx_w-1:0] last_hdr_idx = idx_w'(eth_ip_udp_header_bytes - 1);
  localparam logic [len_w-1:0] ip_overhead  = len_w'(eth_ip_udp_header_bytes);
  localparam logic [len_w-1:0] udp_overhead = len_w'(eth_udp_header_length);
  localparam logic [aw-1:0]    last_word    = aw'(eth_ip_udp_header_words - 1);

  logic [31:0]     tmpl_q [eth_ip_udp_header_words];
  udp_tx_state_e   state_q;
  logic [len_w-1:0] len_q;
  logic [idx_w-1:0] idx_q;
  eth_axis_byte_t  out_q;
  logic            out_valid_q;

  logic [len_w-1:0] l_ip_d;
  logic [len_w-1:0] l_udp_d;
  logic [15:0]      partial_d;
  logic [15:0]      csum_d;
  logic [31:0]      word_d;
  logic [7:0]       hdr_byte_d;
  logic             load_c;
  logic             accept_c;

  // 16-bit ones-complement add with a single end-around carry.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0] + 16'(sum[16]);
  endfunction

  // Template register file; deliberately not reset so software setup survives rst_n.
  always_ff @(posedge clk) begin
    if (header_wr_en_i && (header_wr_addr_i <= last_word)) begin
      tmpl_q[header_wr_addr_i] <= header_wr_data_i;
    end
  end

  // Header byte for the current index, with length and checksum fields patched in.
  always_comb begin
    l_ip_d    = len_q + ip_overhead;
    l_udp_d   = len_q + udp_overhead;
    partial_d = {tmpl_q[2][23:16], tmpl_q[2][31:24]};
    csum_d    = ~ones_add(partial_d, 16'(l_ip_d));
    word_d    = tmpl_q[idx_q[4:2]];
    hdr_byte_d = word_d[7:0];
    case (idx_q[1:0])
      2'd0: hdr_byte_d = word_d[7:0];
      2'd1: hdr_byte_d = word_d[15:8];
      2'd2: hdr_byte_d = word_d[23:16];
      2'd3: hdr_byte_d = word_d[31:24];
    endcase
    case (idx_q)
      idx_w'(2):  hdr_byte_d = l_ip_d[15:8];
      idx_w'(3):  hdr_byte_d = l_ip_d[7:0];
      idx_w'(10): hdr_byte_d = csum_d[15:8];
      idx_w'(11): hdr_byte_d = csum_d[7:0];
      idx_w'(24): hdr_byte_d = l_udp_d[15:8];
      idx_w'(25): hdr_byte_d = l_udp_d[7:0];
      default: ;
    endcase
  end

  assign load_c          = !out_valid_q || tx_if.mac_payload_ready;
  assign tx_if.udp_ready = (state_q == TX_PAYLOAD) && load_c;
  assign accept_c        = tx_if.udp_valid && tx_if.udp_ready;

  // Framing FSM; owns the single output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (load_c) begin
            out_valid_q <= 1'b0;
            out_q.last  <= 1'b0;
          end
          if (tx_if.udp_valid) begin
            len_q   <= tx_if.udp_length;
            idx_q   <= '0;
            state_q <= TX_HEADER;
          end
        end
        TX_HEADER: begin
          if (load_c) begin
            out_q.data  <= hdr_byte_d;
            out_q.last  <= 1'b0;
            out_valid_q <= 1'b1;
            if (idx_q == last_hdr_idx) begin
              idx_q   <= '0;
              state_q <= TX_PAYLOAD;
            end else begin
              idx_q <= idx_q + idx_w'(1);
            end
          end
        end
        TX_PAYLOAD: begin
          if (accept_c) begin
            out_q.data  <= tx_if.udp_data;
            out_q.last  <= tx_if.udp_last;
            out_valid_q <= 1'b1;
            if (tx_if.udp_last) begin
              state_q <= TX_IDLE;
            end
          end else if (load_c) begin
            out_valid_q <= 1'b0;
            out_q.last  <= 1'b0;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_if.mac_payload_data  = out_q.data;
  assign tx_if.mac_payload_last  = out_q.last;
  assign tx_if.mac_payload_valid = out_valid_q;

endmodule

// File: tb/tb_udp_tx.sv
// Directed + randomized bench for udp_tx against a byte-level frame model.
module tb_udp_tx;
  import eth_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic header_wr_en;
  logic [eth_ip_udp_header_addr_width-1:0] header_wr_addr;
  logic [31:0] header_wr_data;

  udp_tx_if tx_if ();

  udp_tx dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .header_wr_en_i   (header_wr_en),
    .header_wr_addr_i (header_wr_addr),
    .header_wr_data_i (header_wr_data),
    .tx_if            (tx_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_data[$];
  int         src_len[$];
  logic [7:0] exp_data[$];
  int         exp_len[$];
  logic [7:0] rx_data[$];
  int         rx_len[$];
  logic [7:0] rx_cur[$];
  int         rx_pos = 0;
  logic [7:0] got[$];
  logic [7:0] ref_frame[$];
  logic [7:0] model_frame[$];
  logic [31:0] tmpl [7];

  int   mode = 0;
  int   gap_pct = 0;
  logic rnd_ready = 1'b1;
  logic man_ready = 1'b1;
  int   start_cyc = 0;
  int   first_cyc = 0;
  bit   first_seen = 1'b0;

  assign tx_if.mac_payload_ready = (mode == 2) ? man_ready : rnd_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fold16(input int s);
    int r;
    r = s;
    while (r > 32'h0000_FFFF) r = (r & 32'h0000_FFFF) + (r >>> 16);
    return r;
  endfunction

  function automatic logic [7:0] tbyte(input int k);
    return tmpl[k / 4][8 * (k % 4) +: 8];
  endfunction

  function automatic logic [7:0] gb(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  // Ones-complement sum over the received 20-byte IPv4 header.
  function automatic int ip_sum();
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) s += int'({gb(2 * i), gb(2 * i + 1)});
    return fold16(s);
  endfunction

  task automatic write_template();
    for (int w = 0; w < 7; w++) begin
      @(posedge clk); #1;
      header_wr_en   = 1'b1;
      header_wr_addr = 3'(w);
      header_wr_data = tmpl[w];
    end
    @(posedge clk); #1;
    header_wr_en = 1'b0;
  endtask

  // Random but well-formed template: partial checksum computed from the halfwords.
  task automatic set_template_random();
    int s;
    logic [15:0] p;
    for (int w = 0; w < 7; w++) tmpl[w] = $urandom;
    tmpl[0][7:0]   = 8'h45;
    tmpl[0][31:16] = 16'h0;
    tmpl[2][31:16] = 16'h0;
    tmpl[6]        = 32'h0;
    s = 0;
    for (int i = 0; i < 10; i++) s += int'({tbyte(2 * i), tbyte(2 * i + 1)});
    p = 16'(fold16(s));
    tmpl[2][23:16] = p[15:8];
    tmpl[2][31:24] = p[7:0];
    write_template();
  endtask

  // Build the expected frame from the template rules, then queue the payload.
  task automatic send_pkt(input int n);
    int lip, ludp, p, c;
    logic [7:0] b;
    lip  = 28 + n;
    ludp = 8 + n;
    p    = int'({tmpl[2][23:16], tmpl[2][31:24]});
    c    = (~fold16(p + lip)) & 32'h0000_FFFF;
    model_frame.delete();
    for (int k = 0; k < 28; k++) begin
      b = tbyte(k);
      if (k == 2)  b = 8'(lip >> 8);
      if (k == 3)  b = 8'(lip);
      if (k == 10) b = 8'(c >> 8);
      if (k == 11) b = 8'(c);
      if (k == 24) b = 8'(ludp >> 8);
      if (k == 25) b = 8'(ludp);
      model_frame.push_back(b);
    end
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      model_frame.push_back(b);
      src_data.push_back(b);
    end
    src_len.push_back(n);
    exp_len.push_back(28 + n);
    foreach (model_frame[i]) exp_data.push_back(model_frame[i]);
  endtask

  task automatic wait_frames(input int k, input int budget);
    int c;
    c = 0;
    while (rx_len.size() < k && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("frames_received", 32'(rx_len.size()), 32'(k));
  endtask

  task automatic check_frame(input string tag);
    int n;
    logic [31:0] mism;
    got.delete();
    ref_frame.delete();
    if (rx_len.size() > 0) begin
      n = rx_len.pop_front();
      repeat (n) got.push_back(rx_data.pop_front());
    end
    if (exp_len.size() > 0) begin
      n = exp_len.pop_front();
      repeat (n) ref_frame.push_back(exp_data.pop_front());
    end
    chk({tag, "_len"}, 32'(got.size()), 32'(ref_frame.size()));
    mism = '1;
    for (int i = 0; i < got.size() && i < ref_frame.size(); i++) begin
      if (got[i] !== ref_frame[i] && mism == '1) mism = 32'(i);
    end
    chk({tag, "_first_bad_byte"}, mism, 32'hFFFF_FFFF);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(tx_if.mac_payload_valid), 32'h0);
    chk({tag, "_last"},  32'(tx_if.mac_payload_last),  32'h0);
    chk({tag, "_data"},  32'(tx_if.mac_payload_data),  32'h0);
    chk({tag, "_udp_ready"}, 32'(tx_if.udp_ready),     32'h0);
  endtask

  // Park MAC ready low for five cycles while frame byte p is presented.
  task automatic stall_at(input int p, input string tag);
    int c;
    c = 0;
    @(posedge clk); #1;
    while (!(tx_if.mac_payload_valid && rx_pos == p) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_reached"}, 32'(rx_pos), 32'(p));
    man_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk({tag, "_data"},      32'(tx_if.mac_payload_data),  32'(model_frame[p]));
      chk({tag, "_valid"},     32'(tx_if.mac_payload_valid), 32'h1);
      chk({tag, "_last"},      32'(tx_if.mac_payload_last),  32'h0);
      chk({tag, "_udp_ready"}, 32'(tx_if.udp_ready),         32'h0);
    end
    @(posedge clk); #1;
    man_ready = 1'b1;
  endtask

  // Payload source: holds a beat until accepted, optional idle gaps between beats.
  initial begin : driver
    bit acc;
    int pos;
    pos = 0;
    tx_if.udp_valid  = 1'b0;
    tx_if.udp_data   = 8'h0;
    tx_if.udp_last   = 1'b0;
    tx_if.udp_length = '0;
    forever begin
      @(negedge clk);
      acc = tx_if.udp_valid && tx_if.udp_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        src_data.delete();
        src_len.delete();
        pos = 0;
        tx_if.udp_valid = 1'b0;
        tx_if.udp_last  = 1'b0;
        continue;
      end
      if (acc) begin
        void'(src_data.pop_front());
        pos++;
        if (pos == src_len[0]) begin
          void'(src_len.pop_front());
          pos = 0;
        end
      end
      if (src_len.size() == 0) begin
        tx_if.udp_valid = 1'b0;
        tx_if.udp_last  = 1'b0;
      end else if (!tx_if.udp_valid || acc) begin
        if (int'($urandom_range(99)) >= gap_pct) begin
          tx_if.udp_valid  = 1'b1;
          tx_if.udp_data   = src_data[0];
          tx_if.udp_last   = (pos == src_len[0] - 1);
          tx_if.udp_length = 16'(src_len[0]);
          if (pos == 0) start_cyc = int'(cyc);
        end else begin
          tx_if.udp_valid = 1'b0;
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      rnd_ready = (mode == 1) ? (int'($urandom_range(99)) < 80) : 1'b1;
    end
  end

  // MAC sink: collects frames and checks stability while stalled.
  initial begin : monitor
    logic [7:0] pd;
    logic       pl;
    bit         stall_prev;
    stall_prev = 1'b0;
    pd = 8'h0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_cur.delete();
        rx_pos     = 0;
        first_seen = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 32'(tx_if.mac_payload_valid), 32'h1);
          chk("hold_data",  32'(tx_if.mac_payload_data),  32'(pd));
          chk("hold_last",  32'(tx_if.mac_payload_last),  32'(pl));
        end
        stall_prev = tx_if.mac_payload_valid && !tx_if.mac_payload_ready;
        pd = tx_if.mac_payload_data;
        pl = tx_if.mac_payload_last;
        if (tx_if.mac_payload_valid && !first_seen) begin
          first_seen = 1'b1;
          first_cyc  = int'(cyc);
        end
        if (tx_if.mac_payload_valid && tx_if.mac_payload_ready) begin
          rx_cur.push_back(tx_if.mac_payload_data);
          rx_pos++;
          if (tx_if.mac_payload_last) begin
            rx_len.push_back(rx_pos);
            foreach (rx_cur[i]) rx_data.push_back(rx_cur[i]);
            rx_cur.delete();
            rx_pos     = 0;
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : main
    int c;
    rst_n          = 1'b0;
    header_wr_en   = 1'b0;
    header_wr_addr = '0;
    header_wr_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-byte packet with a fixed partial checksum of 0xFFF0.
    tmpl[0] = 32'h0000_0045;
    tmpl[1] = 32'h0000_1234;
    tmpl[2] = {8'hF0, 8'hFF, 16'h1140};
    tmpl[3] = 32'h0102_A8C0;
    tmpl[4] = 32'h0202_A8C0;
    tmpl[5] = 32'h3930_D204;
    tmpl[6] = 32'h0;
    write_template();
    send_pkt(1);
    wait_frames(1, 200);
    check_frame("t1");
    chk("t1_lip_hi",  32'(gb(2)),  32'h00);
    chk("t1_lip_lo",  32'(gb(3)),  32'h1D);
    chk("t1_csum_hi", 32'(gb(10)), 32'hFF);
    chk("t1_csum_lo", 32'(gb(11)), 32'hF1);
    chk("t1_ludp_hi", 32'(gb(24)), 32'h00);
    chk("t1_ludp_lo", 32'(gb(25)), 32'h09);
    chk("t1_latency", 32'(first_cyc - start_cyc), 32'd2);

    // Large packet on a random template.
    set_template_random();
    send_pkt(1400);
    wait_frames(1, 3000);
    check_frame("t2");
    chk("t2_lip_hi",  32'(gb(2)),  32'h05);
    chk("t2_lip_lo",  32'(gb(3)),  32'h94);
    chk("t2_ludp_hi", 32'(gb(24)), 32'h05);
    chk("t2_ludp_lo", 32'(gb(25)), 32'h80);
    chk("t2_ip_hdr_sum", 32'(ip_sum()), 32'h0000_FFFF);

    // Random backpressure and source gaps over many packets.
    set_template_random();
    mode    = 1;
    gap_pct = 10;
    for (int i = 0; i < 100; i++) begin
      send_pkt((i % 10 == 0) ? int'($urandom_range(1400, 1)) : int'($urandom_range(120, 1)));
    end
    wait_frames(100, 60000);
    for (int i = 0; i < 100; i++) check_frame("t3");
    mode    = 0;
    gap_pct = 0;

    // Back-to-back packets with no source gap.
    send_pkt(3);
    send_pkt(1);
    send_pkt(5);
    send_pkt(2);
    wait_frames(4, 500);
    for (int i = 0; i < 4; i++) check_frame("t4");

    // Downstream stall on checksum byte and on a payload byte.
    man_ready = 1'b1;
    mode      = 2;
    send_pkt(20);
    stall_at(10, "stall_hdr10");
    stall_at(33, "stall_pay5");
    wait_frames(1, 300);
    check_frame("t5");
    mode = 0;

    // Reset in the middle of a payload, then a fresh template and packet.
    send_pkt(300);
    c = 0;
    @(posedge clk); #1;
    while (rx_pos < 100 && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_mid_payload_reached", 32'(rx_pos >= 100), 32'h1);
    rst_n = 1'b0;
    exp_data.delete();
    exp_len.delete();
    repeat (2) begin
      @(negedge clk);
      chk_outputs_zero("t6_in_reset");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_no_aborted_frame", 32'(rx_len.size()), 32'h0);
    set_template_random();
    send_pkt(50);
    wait_frames(1, 500);
    check_frame("t6");
    chk("t6_ip_hdr_sum", 32'(ip_sum()), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx.md
# udp_tx

Streaming IPv4/UDP transmit framer. It sits between a UDP payload source and the Ethernet MAC payload input. It holds a software-written 28-byte IPv4+UDP header template. For each payload it emits the template with IP total length, UDP length and IP header checksum filled in, followed by the payload bytes, as one AXI-stream frame.

## Interface
- eth_ip_udp_header_addr_width (eth_pkg, 3): header template word address width (7 words used).
- eth_udp_length_width (eth_pkg, 16): payload length field width.
- Clk  in  1  single clock domain.
- Rst_n  in  1  reset, asynchronous, active-low.
- Header_wr_en  in  1  template write strobe.
- Header_wr_addr  in  eth_ip_udp_header_addr_width  template word index 0..6.
- Header_wr_data  in  32  template word; byte k of word is bits [8k+7:8k], transmitted k=0 first.
- Udp_length  in  eth_udp_length_width  payload byte count N (1..1472); sampled only with first beat of a packet.
- Udp_data  in  8  payload byte.
- Udp_valid  in  1  payload beat valid.
- Udp_last  in  1  final payload byte.
- Udp_ready  out  1  payload beat accepted when Udp_valid && Udp_ready.
- Mac_payload_data  out  8  frame byte.
- Mac_payload_valid  out  1  frame beat valid.
- Mac_payload_last  out  1  final frame byte.
- Mac_payload_ready  in  1  downstream accept.

## Operation
- Template: 7×32 register file, written on Header_wr_en. Not cleared by reset. Writes are allowed only while idle; a mid-packet write gives undefined frame content.
- Template contract (software): word0[31:16] = 0, word6[15:0] = 0, word6[31:16] = UDP checksum (0). Word2[31:16] holds the byte-swapped partial checksum P = 16-bit ones-complement sum of the ten big-endian header halfwords, computed with total length and checksum fields at zero.
- Frame = bytes 0..27 from template, then N payload bytes; last only on final payload byte.
- Substitutions, L_ip = 28 + N, L_udp = 8 + N (16-bit):
  - bytes 2,3 = L_ip[15:8], L_ip[7:0]
  - bytes 24,25 = L_udp[15:8], L_udp[7:0]
  - bytes 10,11 = C[15:8], C[7:0], where C = ~(P + L_ip with end-around carry: add 17-bit carry back into the low 16 bits once).
  - P is read as {word2[23:16], word2[31:24]}.
- FSM:
  - IDLE: Udp_ready = 0. On Udp_valid, latch Udp_length, go to HEADER; the first payload beat is not yet consumed.
  - HEADER: index 0..27 loaded into the output register. After byte 27 loads, go to PAYLOAD.
  - PAYLOAD: Udp_ready = output register free. Each accepted beat is copied to the output; Mac_payload_last = Udp_last. On the accepted last beat, go to IDLE.
- Output register loads when !Mac_payload_valid || Mac_payload_ready. Data, last and valid are held stable while valid && !ready.
- Udp_last, not N, ends the frame. Payload count ≠ N is a source error; the frame still ends on Udp_last.

## Timing
- Reset: Mac_payload_valid = 0, Mac_payload_last = 0, Mac_payload_data = 0, Udp_ready = 0, state = IDLE, length/index = 0.
- Reset mid-packet: frame aborted immediately; no further beats; resume in IDLE.
- Latency: Udp_valid rising in IDLE → byte 0 valid 2 cycles later.
- With Mac_payload_ready held 1: one byte per cycle through header and payload, no bubble at the header/payload boundary.
- Udp_ready is combinational from the output-register state and Mac_payload_ready; the payload path has one register stage.
- Back-to-back packets: the next packet may enter HEADER the cycle after the previous last beat is accepted into the output register.
- Checksum is computed combinationally from latched L_ip and template word 2 when byte 10 loads.

## Structure
- eth_pkg holds: eth_ip_udp_header_addr_width = 3, eth_udp_length_width = 16, eth_ipv4_header_length = 20, eth_udp_header_length = 8.
- Single module. Checksum add is a small local function; no sub-module needed.

## Test plan
- N=1, P=0xFFF0, Mac_payload_ready=1 → 29 bytes; bytes 2,3 = 00 1D; bytes 10,11 = FF F1 (0xFFF0 + 0x1D = 0x1000D → 0x000E, inverted); bytes 24,25 = 00 09; last on byte 28 only.
- N=1400, random template → 1428 bytes; bytes 2,3 = 05 94; bytes 24,25 = 05 80; checksum equals recomputed full header sum.
- Random Mac_payload_ready (80%) and random Udp_valid gaps (10%), 100-200 packets of 1..1400 bytes → all frames byte-exact, in order, no loss or duplication.
- Back-to-back packets with zero gap → each frame restarts at header byte 0; no merged frames.
- Rst_n pulsed mid-payload, then new template and packet → outputs 0 during reset; next frame correct.
- Hold Mac_payload_ready=0 for 5 cycles on header byte 10 and on a payload byte → data, last and valid unchanged; Udp_ready = 0 throughout.
